// File: rtl/flappy_game_ctrl_if.sv
// flappy_game_ctrl_if: bundle between the game engine and the game-state controller
// master (engine side): drives frame_tick, flap_req, bird_y, pipe_x0..2, pipe_gap_y0..2
// slave (controller): drives state, pipes_run, bird_run, flap_pending, restart,
//                     score_bcd, high_bcd, collision
interface flappy_game_ctrl_if;
   logic        frame_tick;
   logic        flap_req;
   logic [9:0]  bird_y;
   logic [10:0] pipe_x0, pipe_x1, pipe_x2;
   logic [5:0]  pipe_gap_y0, pipe_gap_y1, pipe_gap_y2;
   logic [1:0]  state;
   logic        pipes_run, bird_run, flap_pending, restart, collision;
   logic [11:0] score_bcd, high_bcd;
   modport master (
      output frame_tick, flap_req, bird_y, pipe_x0, pipe_x1, pipe_x2,
             pipe_gap_y0, pipe_gap_y1, pipe_gap_y2,
      input  state, pipes_run, bird_run, flap_pending, restart, score_bcd, high_bcd, collision
   );
   modport slave (
      input  frame_tick, flap_req, bird_y, pipe_x0, pipe_x1, pipe_x2,
             pipe_gap_y0, pipe_gap_y1, pipe_gap_y2,
      output state, pipes_run, bird_run, flap_pending, restart, score_bcd, high_bcd, collision
   );
endinterface

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: per-frame collision/pass scan, IDLE/PLAY/DEAD/OVER FSM and BCD score
// clk   : system clock
// reset : asynchronous active-high, clears all state
// bus   : flappy_game_ctrl_if.slave (frame snapshot inputs in, state/score/flags out)
module flappy_game_ctrl #(
   parameter int BIRD_X          = 100,
   parameter int BIRD_WIDTH      = 34,
   parameter int BIRD_HEIGHT     = 24,
   parameter int PIPE_WIDTH      = 70,
   parameter int PIPE_GAP_HEIGHT = 120,
   parameter int SCREEN_H        = 480,
   parameter int DEATH_FRAMES    = 60
) (
   input logic               clk,
   input logic               reset,
   flappy_game_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PLAY, DEAD, OVER} state_t;
   localparam logic [11:0] X_LEFT  = 12'(BIRD_X);
   localparam logic [11:0] X_RIGHT = 12'(BIRD_X + BIRD_WIDTH);
   localparam logic [11:0] P_WIDTH = 12'(PIPE_WIDTH);
   localparam logic [11:0] HALF    = 12'(PIPE_GAP_HEIGHT / 2);
   localparam logic [11:0] GROUND  = 12'(SCREEN_H - BIRD_HEIGHT);
   localparam logic [11:0] B_SPAN  = 12'(BIRD_HEIGHT - 1);
   localparam logic [5:0]  D_LAST  = 6'(DEATH_FRAMES - 1);
   state_t      st;
   logic [10:0] snap_x [3];
   logic [10:0] prev_x [3];
   logic [5:0]  snap_g [3];
   logic [9:0]  snap_y;
   logic [2:0]  phase;
   logic        hit_acc;
   logic [1:0]  pass_acc;
   logic [5:0]  dcnt;
   logic [11:0] score, high;
   logic        fp, rst_pulse, coll;
   logic [1:0]  idx;
   logic [11:0] cx, cp, by, center, top, bot, sum;
   logic        overlap, hit, pass;
   // digit-wise BCD add of 0..3; a carry out of the hundreds digit saturates at 999
   function automatic logic [11:0] bcd_add(input logic [11:0] s, input logic [1:0] n);
      logic [4:0] d0, d1, d2;
      d0 = {1'b0, s[3:0]} + {3'b0, n};
      d1 = {1'b0, s[7:4]} + {4'b0, d0 > 5'd9};
      d2 = {1'b0, s[11:8]} + {4'b0, d1 > 5'd9};
      return d2 > 5'd9 ? 12'h999 :
             {d2[3:0], d1 > 5'd9 ? 4'(d1 - 5'd10) : d1[3:0], d0 > 5'd9 ? 4'(d0 - 5'd10) : d0[3:0]};
   endfunction
   always_comb begin
      idx     = phase == 3'd2 ? 2'd1 : phase == 3'd3 ? 2'd2 : 2'd0;
      cx      = {1'b0, snap_x[idx]};
      cp      = {1'b0, prev_x[idx]};
      by      = {2'b0, snap_y};
      center  = {6'b0, snap_g[idx]} * 12'd5 + 12'd85;
      top     = center - HALF;
      bot     = center + HALF;
      overlap = cx < X_RIGHT && cx + P_WIDTH > X_LEFT;
      hit     = (overlap && (by < top || by + B_SPAN > bot)) || (phase == 3'd1 && by >= GROUND);
      // cx <= cp rejects a pipe that wrapped back to its start column
      pass    = cp + P_WIDTH > X_LEFT && cx + P_WIDTH <= X_LEFT && cx <= cp;
      sum     = bcd_add(score, pass_acc);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st        <= IDLE;
         snap_x    <= '{default: '0};
         prev_x    <= '{default: '0};
         snap_g    <= '{default: '0};
         snap_y    <= '0;
         phase     <= '0;
         hit_acc   <= 1'b0;
         pass_acc  <= '0;
         dcnt      <= '0;
         score     <= '0;
         high      <= '0;
         fp        <= 1'b0;
         rst_pulse <= 1'b0;
         coll      <= 1'b0;
      end else begin
         rst_pulse <= 1'b0;
         if (bus.frame_tick && phase == 3'd0) begin
            prev_x   <= snap_x;
            snap_x   <= '{bus.pipe_x0, bus.pipe_x1, bus.pipe_x2};
            snap_g   <= '{bus.pipe_gap_y0, bus.pipe_gap_y1, bus.pipe_gap_y2};
            snap_y   <= bus.bird_y;
            phase    <= 3'd1;
            hit_acc  <= 1'b0;
            pass_acc <= '0;
         end else if (phase != 3'd0) begin
            phase <= phase == 3'd4 ? 3'd0 : phase + 3'd1;
            if (phase != 3'd4) begin
               hit_acc  <= hit_acc | hit;
               pass_acc <= pass_acc + {1'b0, pass};
            end
         end
         if (phase == 3'd4 && st == PLAY) begin
            if (hit_acc) begin
               st   <= DEAD;
               coll <= 1'b1;
            end else score <= sum;
         end
         // a flap accepted in the tick cycle wins over the clear, so it lands on the next frame
         fp <= (bus.flap_req && (st == IDLE || st == PLAY)) ? 1'b1 : bus.frame_tick ? 1'b0 : fp;
         if (bus.flap_req && st == IDLE) st <= PLAY;
         if (st == DEAD && bus.frame_tick) begin
            if (dcnt == D_LAST) begin
               st <= OVER;
               if (score > high) high <= score;
            end else dcnt <= dcnt + 6'd1;
         end
         // clearing both snapshots keeps prev_x zero for the first PLAY frame
         if (st == OVER && bus.flap_req) begin
            st        <= IDLE;
            rst_pulse <= 1'b1;
            score     <= '0;
            coll      <= 1'b0;
            dcnt      <= '0;
            snap_x    <= '{default: '0};
            prev_x    <= '{default: '0};
         end
      end
   end
   assign bus.state        = st;
   assign bus.pipes_run    = st == PLAY;
   assign bus.bird_run     = st == PLAY || st == DEAD;
   assign bus.flap_pending = fp;
   assign bus.restart      = rst_pulse;
   assign bus.score_bcd    = score;
   assign bus.high_bcd     = high;
   assign bus.collision    = coll;
   assert property (@(posedge clk) disable iff (reset) !(bus.frame_tick && phase != 3'd0));
endmodule
